// File: rtl/spi_xfer_sequencer_pkg.sv
// Shared types and widths for the SPI frame sequencer and its register block.
package spi_xfer_sequencer_pkg;

  localparam int SPI_LEN_W  = 5;
  localparam int SPI_BAUD_W = 8;
  localparam int SPI_DLY_W  = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_LEAD,
    SEQ_XFER,
    SEQ_TRAIL
  } spi_seq_state_e;

endpackage

// File: rtl/spi_xfer_sequencer_baud_divider.sv
// SCK half-period down-counter: edge_pulse is high in the cycle the count sits at zero while enabled.
module spi_xfer_sequencer_baud_divider #(
  parameter int BAUD_W = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              reload,
  input  logic              enable,
  input  logic [BAUD_W-1:0] half_period,
  output logic              edge_pulse
);

  logic [BAUD_W-1:0] cnt_reg;

  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_reg <= '0;
    end else if (reload) begin
      cnt_reg <= half_period;
    end else if (enable) begin
      if (cnt_reg == '0) begin
        cnt_reg <= half_period;
      end else begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  assign edge_pulse = enable && (cnt_reg == '0);

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Master-side SPI frame sequencer: slave select, baud-divided SCK, per-edge shift/sample strobes.
// Define SPI_SS_DELAY_EN to add the ss_dly port and stretch the SS lead/trail phases to ss_dly+1.
module spi_xfer_sequencer
  import spi_xfer_sequencer_pkg::*;
#(
  parameter int LEN_W  = SPI_LEN_W,
  parameter int BAUD_W = SPI_BAUD_W,
  parameter int DLY_W  = SPI_DLY_W
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              start,
  input  logic              abort,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [LEN_W-1:0]  data_len,
  input  logic [BAUD_W-1:0] baud_rate,
`ifdef SPI_SS_DELAY_EN
  input  logic [DLY_W-1:0]  ss_dly,
`endif
  output logic              sck,
  output logic              ss_n,
  output logic              load,
  output logic              shift_en,
  output logic              sample_en,
  output logic [LEN_W-1:0]  bit_cnt,
  output logic              busy,
  output logic              done
);

  spi_seq_state_e state_reg, state_next;

  logic             sck_reg, sck_next;
  logic             ss_n_reg, ss_n_next;
  logic             load_reg, load_next;
  logic             shift_en_reg, shift_en_next;
  logic             sample_en_reg, sample_en_next;
  logic             done_reg, done_next;
  logic [LEN_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [DLY_W-1:0] dly_cnt_reg, dly_cnt_next;

  logic              cpol_reg, cpha_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [BAUD_W-1:0] baud_reg;

  logic latch_cfg, div_reload, div_en, div_edge, last_edge;
  logic [DLY_W-1:0] dly_lim;

`ifdef SPI_SS_DELAY_EN
  logic [DLY_W-1:0] dly_reg;
  assign dly_lim = dly_reg;
`else
  assign dly_lim = '0;
`endif

  spi_xfer_sequencer_baud_divider #(
    .BAUD_W(BAUD_W)
  ) u_baud (
    .pclk       (pclk),
    .preset     (preset),
    .reload     (div_reload),
    .enable     (div_en),
    .half_period(baud_reg),
    .edge_pulse (div_edge)
  );

  always_comb begin
    state_next     = state_reg;
    sck_next       = sck_reg;
    ss_n_next      = ss_n_reg;
    load_next      = 1'b0;
    shift_en_next  = 1'b0;
    sample_en_next = 1'b0;
    done_next      = 1'b0;
    bit_cnt_next   = bit_cnt_reg;
    dly_cnt_next   = dly_cnt_reg;
    latch_cfg      = 1'b0;
    div_reload     = 1'b0;
    div_en         = 1'b0;
    last_edge      = 1'b0;

    case (state_reg)
      SEQ_IDLE: begin
        sck_next  = cpol;
        ss_n_next = 1'b1;
        if (start && !abort) begin
          latch_cfg    = 1'b1;
          state_next   = SEQ_LEAD;
          ss_n_next    = 1'b0;
          load_next    = 1'b1;
          bit_cnt_next = '0;
          dly_cnt_next = '0;
        end
      end
      SEQ_LEAD: begin
        if (dly_cnt_reg == dly_lim) begin
          state_next = SEQ_XFER;
          div_reload = 1'b1;
        end else begin
          dly_cnt_next = dly_cnt_reg + 1'b1;
        end
      end
      SEQ_XFER: begin
        div_en = 1'b1;
        if (div_edge) begin
          sck_next = ~sck_reg;
          // SCK still at its idle level means this toggle is the leading edge of a bit
          if (sck_reg == cpol_reg) begin
            shift_en_next  = cpha_reg;
            sample_en_next = ~cpha_reg;
          end else begin
            last_edge      = (bit_cnt_reg == len_reg);
            bit_cnt_next   = bit_cnt_reg + 1'b1;
            sample_en_next = cpha_reg;
            shift_en_next  = ~cpha_reg & ~last_edge;
            if (last_edge) begin
              state_next   = SEQ_TRAIL;
              dly_cnt_next = '0;
            end
          end
        end
      end
      SEQ_TRAIL: begin
        if (dly_cnt_reg == dly_lim) begin
          state_next = SEQ_IDLE;
          ss_n_next  = 1'b1;
          done_next  = 1'b1;
        end else begin
          dly_cnt_next = dly_cnt_reg + 1'b1;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase

    if (abort && (state_reg != SEQ_IDLE)) begin
      state_next     = SEQ_IDLE;
      ss_n_next      = 1'b1;
      sck_next       = cpol_reg;
      load_next      = 1'b0;
      shift_en_next  = 1'b0;
      sample_en_next = 1'b0;
      done_next      = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_reg     <= SEQ_IDLE;
      sck_reg       <= 1'b0;
      ss_n_reg      <= 1'b1;
      load_reg      <= 1'b0;
      shift_en_reg  <= 1'b0;
      sample_en_reg <= 1'b0;
      done_reg      <= 1'b0;
      bit_cnt_reg   <= '0;
      dly_cnt_reg   <= '0;
      cpol_reg      <= 1'b0;
      cpha_reg      <= 1'b0;
      len_reg       <= '0;
      baud_reg      <= '0;
`ifdef SPI_SS_DELAY_EN
      dly_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      sck_reg       <= sck_next;
      ss_n_reg      <= ss_n_next;
      load_reg      <= load_next;
      shift_en_reg  <= shift_en_next;
      sample_en_reg <= sample_en_next;
      done_reg      <= done_next;
      bit_cnt_reg   <= bit_cnt_next;
      dly_cnt_reg   <= dly_cnt_next;
      if (latch_cfg) begin
        cpol_reg <= cpol;
        cpha_reg <= cpha;
        len_reg  <= data_len;
        baud_reg <= baud_rate;
`ifdef SPI_SS_DELAY_EN
        dly_reg  <= ss_dly;
`endif
      end
    end
  end

  assign sck       = sck_reg;
  assign ss_n      = ss_n_reg;
  assign load      = load_reg;
  assign shift_en  = shift_en_reg;
  assign sample_en = sample_en_reg;
  assign bit_cnt   = bit_cnt_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != SEQ_IDLE);

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer: timeline model of each frame plus literal per-frame totals.
module tb_spi_xfer_sequencer;

  typedef struct packed {
    logic       sck;
    logic       ss_n;
    logic       load;
    logic       shift;
    logic       sample;
    logic       busy;
    logic       done;
    logic [4:0] bit_cnt;
  } obs_t;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [4:0] data_len = '0;
  logic [7:0] baud_rate = '0;
`ifdef SPI_SS_DELAY_EN
  logic [3:0] ss_dly = '0;
`endif
  logic       sck, ss_n, load, shift_en, sample_en, busy, done;
  logic [4:0] bit_cnt;

  int tests = 0;
  int fails = 0;
  int n_shift = 0, n_sample = 0, n_load = 0, n_done = 0, n_sslow = 0, n_edge = 0;
  int b_shift, b_sample, b_load, b_done, b_sslow, b_edge;
  logic prev_sck = 1'b0;

  always #5 pclk = ~pclk;

  spi_xfer_sequencer dut (
    .pclk     (pclk),
    .preset   (preset),
    .start    (start),
    .abort    (abort),
    .cpol     (cpol),
    .cpha     (cpha),
    .data_len (data_len),
    .baud_rate(baud_rate),
`ifdef SPI_SS_DELAY_EN
    .ss_dly   (ss_dly),
`endif
    .sck      (sck),
    .ss_n     (ss_n),
    .load     (load),
    .shift_en (shift_en),
    .sample_en(sample_en),
    .bit_cnt  (bit_cnt),
    .busy     (busy),
    .done     (done)
  );

  // ---------------- model: frame expressed as a timeline of r = cycles since start ----------------
  obs_t e = '0;
  bit   m_valid = 1'b0;
  bit   m_active = 1'b0;
  int   m_r = 0, m_L = 1, m_H = 1, m_N = 1;
  logic m_cpol = 1'b0, m_cpha = 1'b0;

  // Lead phase covers r < L; SCK edge k (1..2N) becomes visible at r = L + k*H.
  function automatic obs_t frame_obs(int r, int L, int H, int N, logic cp, logic ph);
    obs_t o;
    int   k;
    o      = '0;
    o.busy = 1'b1;
    o.load = (r == 0);
    k = (r < L) ? 0 : (r - L) / H;
    if (k > 2 * N) k = 2 * N;
    o.sck     = cp ^ k[0];
    o.bit_cnt = 5'(k / 2);
    if (k >= 1 && (r - L) == k * H) begin
      if (k % 2 == 1) begin
        o.shift  = ph;
        o.sample = !ph;
      end else begin
        o.sample = ph;
        o.shift  = !ph && (k < 2 * N);
      end
    end
    return o;
  endfunction

  always @(posedge pclk) begin : model
    obs_t n;
    int   r;
    n = e;
    if (preset) begin
      n = '0;
      n.ss_n = 1'b1;
      m_active <= 1'b0;
      m_valid  <= 1'b1;
    end else if (m_active) begin
      if (abort) begin
        n.sck = m_cpol; n.ss_n = 1'b1; n.load = 1'b0; n.shift = 1'b0;
        n.sample = 1'b0; n.busy = 1'b0; n.done = 1'b0;
        m_active <= 1'b0;
      end else begin
        r = m_r + 1;
        m_r <= r;
        if (r == 2 * m_L + 2 * m_N * m_H) begin
          n = '0;
          n.sck = m_cpol; n.ss_n = 1'b1; n.done = 1'b1; n.bit_cnt = 5'(m_N);
          m_active <= 1'b0;
        end else begin
          n = frame_obs(r, m_L, m_H, m_N, m_cpol, m_cpha);
        end
      end
    end else begin
      n.sck = cpol; n.ss_n = 1'b1; n.load = 1'b0; n.shift = 1'b0;
      n.sample = 1'b0; n.busy = 1'b0; n.done = 1'b0;
      if (start && !abort) begin
        m_active <= 1'b1;
        m_r      <= 0;
        m_cpol   <= cpol;
        m_cpha   <= cpha;
        m_N      <= int'(data_len) + 1;
        m_H      <= int'(baud_rate) + 1;
`ifdef SPI_SS_DELAY_EN
        m_L      <= int'(ss_dly) + 1;
`else
        m_L      <= 1;
`endif
        n = frame_obs(0, 1, 1, 1, cpol, cpha);
      end
    end
    e <= n;
  end

  // ---------------- per-cycle compare and running totals ----------------
  task automatic step();
    obs_t a;
    @(negedge pclk);
    a = {sck, ss_n, load, shift_en, sample_en, busy, done, bit_cnt};
    if (m_valid) begin
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL model_cmp @%0t got sck/ss_n/load/shift/sample/busy/done/bit_cnt=%b want=%b",
                 $time, a, e);
      end
    end
    if (shift_en)  n_shift++;
    if (sample_en) n_sample++;
    if (load)      n_load++;
    if (done)      n_done++;
    if (!ss_n)     n_sslow++;
    if (!ss_n && sck != prev_sck) n_edge++;
    prev_sck = sck;
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end else begin
      $display("[TB] %s = %0d ok", name, got);
    end
  endtask

  task automatic snap();
    b_shift = n_shift; b_sample = n_sample; b_load = n_load;
    b_done = n_done; b_sslow = n_sslow; b_edge = n_edge;
  endtask

  task automatic cfg(input logic pol, input logic pha, input int len, input int baud);
    cpol = pol; cpha = pha; data_len = 5'(len); baud_rate = 8'(baud);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = n_done;
    int i  = 0;
    while (n_done == d0 && i < budget) begin
      step();
      i++;
    end
    if (n_done == d0) begin
      tests++;
      fails++;
      $display("FAIL %s timeout waiting for done", name);
    end
  endtask

  task automatic wait_edges(input string name, input int target, input int budget);
    int i = 0;
    while (n_edge < target && i < budget) begin
      step();
      i++;
    end
    if (n_edge < target) begin
      tests++;
      fails++;
      $display("FAIL %s timeout waiting for sck edge %0d", name, target);
    end
  endtask

  initial begin
    repeat (3) step();
    check("reset_ss_n", ss_n, 1);
    check("reset_sck", sck, 0);
    check("reset_busy", busy, 0);
    check("reset_bit_cnt", bit_cnt, 0);
    preset = 1'b0;
    step();

    // 8-bit mode 0, two-cycle half period
    cfg(0, 0, 7, 1); step(); snap();
    pulse_start();
    wait_done("t1", 200);
    check("t1_sample_en", n_sample - b_sample, 8);
    check("t1_shift_en", n_shift - b_shift, 7);
    check("t1_load", n_load - b_load, 1);
    check("t1_done", n_done - b_done, 1);
    check("t1_edges", n_edge - b_edge, 16);
    check("t1_ss_low", n_sslow - b_sslow, 34);
    check("t1_bit_cnt", bit_cnt, 8);

    // single-bit frame, cpol=1 cpha=1, pclk/2
    cfg(1, 1, 0, 0); step(); step();
    check("t2_idle_sck", sck, 1);
    snap();
    pulse_start();
    wait_done("t2", 50);
    check("t2_shift_en", n_shift - b_shift, 1);
    check("t2_sample_en", n_sample - b_sample, 1);
    check("t2_edges", n_edge - b_edge, 2);
    check("t2_ss_low", n_sslow - b_sslow, 4);
    step();
    check("t2_bit_cnt_held", bit_cnt, 1);

    // start while busy is ignored
    cfg(0, 1, 3, 2); step(); snap();
    pulse_start();
    wait_edges("t3", b_edge + 2, 100);
    pulse_start();
    wait_done("t3", 100);
    repeat (6) step();
    check("t3_done_once", n_done - b_done, 1);
    check("t3_ss_low", n_sslow - b_sslow, 26);
    snap();
    pulse_start();
    wait_done("t3b", 100);
    check("t3_restart_done", n_done - b_done, 1);

    // abort on 5th edge
    cfg(0, 0, 7, 1); step(); snap();
    pulse_start();
    wait_edges("t4", b_edge + 5, 100);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_abort_busy", busy, 0);
    check("t4_abort_ss_n", ss_n, 1);
    check("t4_abort_sck", sck, 0);
    repeat (4) step();
    check("t4_no_done", n_done - b_done, 0);
    check("t4_edges", n_edge - b_edge, 5);
    cfg(1, 0, 1, 0); step(); snap();
    pulse_start();
    wait_done("t4b", 50);
    check("t4_clean_sample", n_sample - b_sample, 2);
    check("t4_clean_shift", n_shift - b_shift, 1);

    // abort with start in IDLE
    snap();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    step();
    check("t4c_start_abort_busy", busy, 0);
    check("t4c_start_abort_load", n_load - b_load, 0);

    // config changes mid-frame are ignored
    cfg(0, 0, 3, 3); step(); snap();
    pulse_start();
    step(); step();
    baud_rate = 8'd0; cpol = 1'b1;
    wait_done("t5", 100);
    check("t5_edges", n_edge - b_edge, 8);
    check("t5_ss_low", n_sslow - b_sslow, 34);
    step();
    check("t5_idle_new_cpol", sck, 1);

    // 32-bit frame: bit_cnt wraps in its 5-bit field
    cfg(0, 1, 31, 0); step(); snap();
    pulse_start();
    wait_done("t7", 300);
    check("t7_edges", n_edge - b_edge, 64);
    check("t7_sample_en", n_sample - b_sample, 32);
    check("t7_shift_en", n_shift - b_shift, 32);
    check("t7_ss_low", n_sslow - b_sslow, 66);
    check("t7_bit_cnt", bit_cnt, 0);

    // preset mid-transfer
`ifdef SPI_SS_DELAY_EN
    ss_dly = 4'd3;
`endif
    cfg(1, 0, 7, 2); step(); snap();
    pulse_start();
    wait_edges("t6", b_edge + 3, 200);
    preset = 1'b1;
    step();
    check("t6_preset_ss_n", ss_n, 1);
    check("t6_preset_sck", sck, 0);
    check("t6_preset_busy", busy, 0);
    check("t6_preset_bit_cnt", bit_cnt, 0);
    preset = 1'b0;
    repeat (3) step();
    check("t6_no_done", n_done - b_done, 0);
    check("t6_idle_sck", sck, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
